// File: rtl/pw_run_checker.sv
// Digit-run checker for six-digit (parameterisable) BCD password candidates.
// Walks adjacent digit pairs one per cycle and counts passing candidates.
module pw_run_checker #(
    parameter int    UUID   = 0,
    parameter string NAME   = "",
    parameter int    DIGITS = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*DIGITS-1:0] in_digits,
    input  logic              count_clr,
    output logic              out_valid,
    output logic              out_pass,
    output logic [15:0]       pass_count
);

    localparam int W = 4 * DIGITS;
    localparam logic [2:0] LAST_IDX = 3'(DIGITS - 2);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t state_q;
    state_t state_nx;

    logic [W-1:0] dig_q;
    logic [2:0]   idx_q;
    logic [2:0]   run_len_q;
    logic         has_pair_q;
    logic         mono_q;
    logic         pass_q;
    logic [15:0]  count_q;

    logic [3:0]   nib_a;
    logic [3:0]   nib_b;
    logic         pair_eq;
    logic         pair_dec;
    logic [2:0]   run_len_nx;
    logic         has_pair_nx;
    logic         mono_nx;
    logic         pass_nx;
    logic         last_pair;
    logic         accept;
    logic         finish;

    // Identification parameters carry no logic; this keeps them referenced.
    if ((UUID < 0) && (NAME != "")) begin : g_id_unused
    end

    // Compare the two leading nibbles of the shifting digit window.
    always_comb begin
        nib_a       = dig_q[W-1 -: 4];
        nib_b       = dig_q[W-5 -: 4];
        pair_eq     = (nib_a == nib_b);
        pair_dec    = (nib_b < nib_a);
        run_len_nx  = run_len_q;
        has_pair_nx = has_pair_q;
        if (pair_eq) begin
            if (run_len_q != 3'd7) begin
                run_len_nx = run_len_q + 3'd1;
            end
        end else begin
            if (run_len_q == 3'd2) begin
                has_pair_nx = 1'b1;
            end
            run_len_nx = 3'd1;
        end
        mono_nx   = mono_q & ~pair_dec;
        pass_nx   = mono_nx & (has_pair_nx | (run_len_nx == 3'd2));
        last_pair = (idx_q == LAST_IDX);
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nx  = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (last_pair) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Scan datapath: latch on accept, then shift one digit per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dig_q      <= '0;
            idx_q      <= 3'd0;
            run_len_q  <= 3'd1;
            has_pair_q <= 1'b0;
            mono_q     <= 1'b1;
        end else if (accept) begin
            dig_q      <= in_digits;
            idx_q      <= 3'd0;
            run_len_q  <= 3'd1;
            has_pair_q <= 1'b0;
            mono_q     <= 1'b1;
        end else if (state_q == SCAN) begin
            dig_q      <= {dig_q[W-5:0], 4'h0};
            run_len_q  <= run_len_nx;
            has_pair_q <= has_pair_nx;
            mono_q     <= mono_nx;
            if (!last_pair) begin
                idx_q <= idx_q + 3'd1;
            end
        end
    end

    // Verdict register; holds until the next candidate finishes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_q <= 1'b0;
        end else if (finish) begin
            pass_q <= pass_nx;
        end
    end

    // Saturating pass counter; a clear beats a coincident increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 16'h0000;
        end else if (count_clr) begin
            count_q <= 16'h0000;
        end else if (finish && pass_nx && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'h0001;
        end
    end

    assign out_pass   = pass_q;
    assign pass_count = count_q;

endmodule

// File: tb/tb_pw_run_checker.sv
// Directed bench for pw_run_checker with hand-computed verdicts.
// Every comparison goes through the check task.
module tb_pw_run_checker;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_digits;
    logic        count_clr;
    logic        out_valid;
    logic        out_pass;
    logic [15:0] pass_count;

    int n_checks;
    int n_errors;

    pw_run_checker #(
        .UUID   (0),
        .NAME   ("dut"),
        .DIGITS (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_digits  (in_digits),
        .count_clr  (count_clr),
        .out_valid  (out_valid),
        .out_pass   (out_pass),
        .pass_count (pass_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One candidate through the block; optional clear on the DONE edge.
    task automatic run_cand(input logic [23:0] d, input logic exp_pass,
                            input logic [15:0] exp_cnt,
                            input logic clr_at_done);
        int lat;
        bit seen;
        @(negedge clk);
        check("ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_digits = d;
        @(negedge clk);
        in_valid  = 1'b0;
        in_digits = '0;
        lat  = 1;
        seen = 0;
        while (!seen && lat <= 20) begin
            if (clr_at_done && lat == 5) count_clr = 1'b1;
            if (out_valid) begin
                seen = 1;
            end else begin
                @(negedge clk);
                count_clr = 1'b0;
                lat++;
            end
        end
        check("latency", 32'(lat), 32'd6);
        check("pass", 32'(out_pass), 32'(exp_pass));
        check("count", 32'(pass_count), 32'(exp_cnt));
        @(negedge clk);
        check("vld_drop", 32'(out_valid), 32'd0);
        check("ready_back", 32'(in_ready), 32'd1);
        check("pass_hold", 32'(out_pass), 32'(exp_pass));
    endtask

    initial begin
        int pulses;
        int last_k;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_digits = 24'h112233;
        count_clr = 1'b0;

        // Reset state, with in_valid high to show nothing is taken.
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pass", 32'(out_pass), 32'd0);
        check("rst_count", 32'(pass_count), 32'd0);
        in_valid = 1'b0;
        rst      = 1'b1;

        // Passing candidates.
        run_cand(24'h112233, 1'b1, 16'd1, 1'b0);
        run_cand(24'h111122, 1'b1, 16'd2, 1'b0);
        run_cand(24'h113456, 1'b1, 16'd3, 1'b0);
        // Failing candidates.
        run_cand(24'h123444, 1'b0, 16'd3, 1'b0);
        run_cand(24'h111111, 1'b0, 16'd3, 1'b0);
        run_cand(24'h223450, 1'b0, 16'd3, 1'b0);
        run_cand(24'h112210, 1'b0, 16'd3, 1'b0);
        run_cand(24'h111223, 1'b1, 16'd4, 1'b0);
        // Nibbles above 9 compare as plain values.
        run_cand(24'h11AABB, 1'b1, 16'd5, 1'b0);

        // Continuous in_valid: three accepts in 21 cycles, pulses 7 apart.
        @(negedge clk);
        in_valid  = 1'b1;
        in_digits = 24'h112233;
        pulses = 0;
        last_k = 0;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                if (last_k != 0) check("spacing", 32'(k - last_k), 32'd7);
                last_k = k;
            end
        end
        in_valid = 1'b0;
        check("cont_pulses", 32'(pulses), 32'd3);
        check("cont_count", 32'(pass_count), 32'd8);

        // Clear on the same edge as a passing DONE entry.
        run_cand(24'h112233, 1'b1, 16'd0, 1'b1);

        // Plain clear in IDLE.
        run_cand(24'h112233, 1'b1, 16'd1, 1'b0);
        @(negedge clk);
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
        check("idle_clr", 32'(pass_count), 32'd0);

        // Build pass_count up to 5.
        for (int i = 1; i <= 5; i++) begin
            run_cand(24'h112233, 1'b1, 16'(i), 1'b0);
        end

        // Reset in the middle of a scan.
        @(negedge clk);
        in_valid  = 1'b1;
        in_digits = 24'h112233;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("async_count", 32'(pass_count), 32'd0);
        check("async_ready", 32'(in_ready), 32'd1);
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_pass", 32'(out_pass), 32'd0);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("rst_no_pulse", 32'(pulses), 32'd0);
        run_cand(24'h113456, 1'b1, 16'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
